// File: rtl/async_fifo.sv
// async_fifo: single-clock show-ahead FIFO, DP x W, with full/afull/empty/aempty flags
// selectable as pointer-derived combinational or flop-driven outputs. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module async_fifo #(
  parameter int W       = 8,
  parameter int DP      = 4,
  parameter int WR_FAST = 1,
  parameter int RD_FAST = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  output logic         afull,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         aempty
);

  localparam int AW = $clog2(DP);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] OCC_FULL   = PW'(DP);
  localparam logic [PW-1:0] OCC_AFULL  = PW'(DP - 1);
  localparam logic [PW-1:0] OCC_AEMPTY = PW'(1);
  localparam logic [PW-1:0] OCC_EMPTY  = '0;

  logic [W-1:0]  r_mem [DP];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic          w_push;
  logic          w_pop;

  // Blocked requests are simply dropped; the flags gate both sides.
  assign w_push = wr_en & ~full;
  assign w_pop  = rd_en & ~empty;

  assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  generate
    if (WR_FAST != 0) begin : g_wr_fast
      logic [PW-1:0] w_occ;
      assign w_occ = r_wr_ptr - r_rd_ptr;
      assign full  = (w_occ == OCC_FULL);
      assign afull = (w_occ >= OCC_AFULL);
    end else begin : g_wr_reg
      // Flops are loaded from next-state pointers so they match the fast path each cycle.
      logic [PW-1:0] w_occ_nxt;
      logic          r_full;
      logic          r_afull;
      assign w_occ_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_full  <= 1'b0;
          r_afull <= 1'b0;
        end else begin
          r_full  <= (w_occ_nxt == OCC_FULL);
          r_afull <= (w_occ_nxt >= OCC_AFULL);
        end
      end
      assign full  = r_full;
      assign afull = r_afull;
    end
  endgenerate

  generate
    if (RD_FAST != 0) begin : g_rd_fast
      logic [PW-1:0] w_occ;
      assign w_occ  = r_wr_ptr - r_rd_ptr;
      assign empty  = (w_occ == OCC_EMPTY);
      assign aempty = (w_occ <= OCC_AEMPTY);
    end else begin : g_rd_reg
      logic [PW-1:0] w_occ_nxt;
      logic          r_empty;
      logic          r_aempty;
      assign w_occ_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_empty  <= 1'b1;
          r_aempty <= 1'b1;
        end else begin
          r_empty  <= (w_occ_nxt == OCC_EMPTY);
          r_aempty <= (w_occ_nxt <= OCC_AEMPTY);
        end
      end
      assign empty  = r_empty;
      assign aempty = r_aempty;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_async_fifo.sv
// tb_async_fifo: drives a fast-flag and a registered-flag FIFO in lockstep against a queue model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_async_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wr_data;

  logic [7:0] rd_data_f, rd_data_s;
  logic       full_f, afull_f, empty_f, aempty_f;
  logic       full_s, afull_s, empty_s, aempty_s;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  async_fifo #(.W(8), .DP(4), .WR_FAST(1), .RD_FAST(1)) u_fast (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full_f),
    .afull   (afull_f),
    .rd_en   (rd_en),
    .rd_data (rd_data_f),
    .empty   (empty_f),
    .aempty  (aempty_f)
  );

  async_fifo #(.W(8), .DP(4), .WR_FAST(0), .RD_FAST(0)) u_slow (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full_s),
    .afull   (afull_s),
    .rd_en   (rd_en),
    .rd_data (rd_data_s),
    .empty   (empty_s),
    .aempty  (aempty_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flag nibble order: {empty, aempty, full, afull}
  task automatic chk_flags(input string tag);
    int         n;
    logic [3:0] exp;
    n   = q.size();
    exp = {(n == 0), (n <= 1), (n == 4), (n >= 3)};
    chk({tag, " flags_fast"}, {28'b0, empty_f, aempty_f, full_f, afull_f}, {28'b0, exp});
    chk({tag, " flags_slow"}, {28'b0, empty_s, aempty_s, full_s, afull_s}, {28'b0, exp});
    if (n > 0) begin
      chk({tag, " head_fast"}, 32'(rd_data_f), 32'(q[0]));
      chk({tag, " head_slow"}, 32'(rd_data_s), 32'(q[0]));
    end
  endtask

  task automatic step(input logic we, input logic [7:0] wd, input logic re, input string tag);
    bit do_push, do_pop;
    @(negedge clk);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    do_pop  = re && (q.size() > 0);
    do_push = we && (q.size() < 4);
    if (do_pop) begin
      chk({tag, " pop_fast"}, 32'(rd_data_f), 32'(q[0]));
      chk({tag, " pop_slow"}, 32'(rd_data_s), 32'(q[0]));
      void'(q.pop_front());
    end
    if (do_push) q.push_back(wd);
    @(posedge clk);
    #1;
    chk_flags(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_flags("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fill, attempt overflow with 0xFF, then drain in order.
    step(1'b1, 8'hA1, 1'b0, "push_a1");
    step(1'b1, 8'hA2, 1'b0, "push_a2");
    step(1'b1, 8'hA3, 1'b0, "push_a3");
    step(1'b1, 8'hA4, 1'b0, "push_a4");
    step(1'b1, 8'hFF, 1'b0, "push_full");
    step(1'b1, 8'hFF, 1'b0, "push_full2");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, "drain");

    // Underflow attempts, then a single push becomes visible after one edge.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "pop_empty");
    step(1'b1, 8'h55, 1'b0, "push_55");
    step(1'b0, 8'h00, 1'b1, "pop_55");

    // Empty with both requests: push wins, pop ignored.
    step(1'b1, 8'h66, 1'b1, "both_empty");

    // Steady occupancy 2 through pointer wrap.
    step(1'b1, 8'h10, 1'b0, "occ2_fill");
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b1, "stream");

    // Full with both requests: head popped, push dropped.
    step(1'b1, 8'h30, 1'b0, "fill3");
    step(1'b1, 8'h31, 1'b0, "fill4");
    step(1'b1, 8'hEE, 1'b1, "both_full");

    // Asynchronous reset pulse between edges at occupancy 3.
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    q.delete();
    chk_flags("async_reset");
    #1 reset_n = 1'b1;

    step(1'b1, 8'h77, 1'b0, "post_push1");
    step(1'b1, 8'h78, 1'b0, "post_push2");
    step(1'b0, 8'h00, 1'b1, "post_pop1");
    step(1'b0, 8'h00, 1'b1, "post_pop2");
    step(1'b0, 8'h00, 1'b1, "post_pop_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
